// File: rtl/tx_pkg.sv
// Shared definitions for the transmit sender: default word width, FSM state
// encoding and counter widths.
package tx_pkg;

    localparam int TX_DATA_W  = 5;
    localparam int SENT_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_LOAD  = 2'b01,
        ST_VALID = 2'b10,
        ST_DONE  = 2'b11
    } tx_state_e;

endpackage

// File: rtl/tx_fifo.sv
// Small synchronous FIFO; pointers carry an extra wrap bit so full and empty
// come straight from registered state.
module tx_fifo
    import tx_pkg::*;
#(
    parameter int DATA_W = TX_DATA_W,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] head_o,
    output logic              full_o,
    output logic              empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic              wr_en;
    logic              rd_en;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    // A push while full is dropped regardless of a same-cycle pop.
    assign wr_en = push_i & ~full_o;
    assign rd_en = pop_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

endmodule

// File: rtl/tx_sender_fsm.sv
// Transmit stage: drains the local FIFO one word at a time onto a valid/ready
// link, counts completed transfers and flags a stalled receiver.
module tx_sender_fsm
    import tx_pkg::*;
#(
    parameter int DATA_W  = TX_DATA_W,
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push_i,
    input  logic [DATA_W-1:0]     data_i,
    output logic                  full_o,
    output logic                  overflow_o,
    output logic                  valid_o,
    output logic [DATA_W-1:0]     data_o,
    input  logic                  ready_i,
    output logic [1:0]            state_o,
    output logic [SENT_CNT_W-1:0] sent_cnt_o,
    output logic                  timeout_o
);

    localparam int WAIT_W = $clog2(TIMEOUT);

    tx_state_e             state_q, state_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic                  valid_q, valid_d;
    logic [SENT_CNT_W-1:0] sent_q, sent_d;
    logic [WAIT_W-1:0]     wait_q, wait_d;
    logic                  timeout_q, timeout_d;
    logic                  overflow_q, overflow_d;

    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DATA_W-1:0]     fifo_head;

    tx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push_i),
        .data_i  (data_i),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign fifo_pop = (state_q == ST_LOAD);

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        sent_d     = sent_q;
        wait_d     = wait_q;
        timeout_d  = 1'b0;
        overflow_d = push_i & fifo_full;
        unique case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                data_d  = fifo_head;
                state_d = ST_VALID;
            end
            ST_VALID: begin
                if (ready_i) begin
                    state_d = ST_DONE;
                    sent_d  = sent_q + SENT_CNT_W'(1);
                    wait_d  = '0;
                end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                    // Stall is reported but the word stays offered.
                    timeout_d = 1'b1;
                    wait_d    = '0;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = fifo_empty ? ST_IDLE : ST_LOAD;
            end
            default: state_d = ST_IDLE;
        endcase
        valid_d = (state_d == ST_VALID);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            data_q     <= '0;
            valid_q    <= 1'b0;
            sent_q     <= '0;
            wait_q     <= '0;
            timeout_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            sent_q     <= sent_d;
            wait_q     <= wait_d;
            timeout_q  <= timeout_d;
            overflow_q <= overflow_d;
        end
    end

    assign full_o     = fifo_full;
    assign overflow_o = overflow_q;
    assign valid_o    = valid_q;
    assign data_o     = data_q;
    assign state_o    = state_q;
    assign sent_cnt_o = sent_q;
    assign timeout_o  = timeout_q;

endmodule

// File: tb/tb_tx_sender_fsm.sv
// Directed bench for tx_sender_fsm with hand-computed expectations.
module tb_tx_sender_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic       push_i;
    logic [4:0] data_i;
    logic       full_o;
    logic       overflow_o;
    logic       valid_o;
    logic [4:0] data_o;
    logic       ready_i;
    logic [1:0] state_o;
    logic [7:0] sent_cnt_o;
    logic       timeout_o;

    int n_vec = 0;
    int n_err = 0;

    tx_sender_fsm #(
        .DATA_W  (5),
        .DEPTH   (4),
        .TIMEOUT (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .push_i     (push_i),
        .data_i     (data_i),
        .full_o     (full_o),
        .overflow_o (overflow_o),
        .valid_o    (valid_o),
        .data_o     (data_o),
        .ready_i    (ready_i),
        .state_o    (state_o),
        .sent_cnt_o (sent_cnt_o),
        .timeout_o  (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max_cyc);
        int n;
        n = 0;
        while (!valid_o && n < max_cyc) begin
            tick();
            n++;
        end
        check("wait_valid", 32'(valid_o), 32'd1);
    endtask

    task automatic expect_word(input logic [4:0] exp);
        wait_valid(8);
        check("word_data", 32'(data_o), 32'(exp));
        tick();
        check("word_done", 32'(state_o), 32'd3);
    endtask

    initial begin
        int to_cnt;
        int first_to;
        logic data_bad;

        rst = 1'b1; push_i = 1'b0; data_i = '0; ready_i = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_data", 32'(data_o), 32'd0);
        check("rst_state", 32'(state_o), 32'd0);
        check("rst_sent", 32'(sent_cnt_o), 32'd0);
        check("rst_full", 32'(full_o), 32'd0);
        check("rst_ovf", 32'(overflow_o), 32'd0);
        check("rst_to", 32'(timeout_o), 32'd0);

        // Single word, ready held high through IDLE/LOAD
        ready_i = 1'b1;
        push_i = 1'b1; data_i = 5'h0A;
        tick();
        push_i = 1'b0;
        check("t1_e0_state", 32'(state_o), 32'd0);
        tick();
        check("t1_e1_state", 32'(state_o), 32'd1);
        check("t1_e1_valid", 32'(valid_o), 32'd0);
        check("t1_e1_sent", 32'(sent_cnt_o), 32'd0);
        tick();
        check("t1_e2_state", 32'(state_o), 32'd2);
        check("t1_e2_valid", 32'(valid_o), 32'd1);
        check("t1_e2_data", 32'(data_o), 32'h0A);
        check("t1_e2_sent", 32'(sent_cnt_o), 32'd0);
        tick();
        check("t1_e3_state", 32'(state_o), 32'd3);
        check("t1_e3_valid", 32'(valid_o), 32'd0);
        check("t1_e3_sent", 32'(sent_cnt_o), 32'd1);
        check("t1_e3_data", 32'(data_o), 32'h0A);
        tick();
        check("t1_e4_state", 32'(state_o), 32'd0);

        // Fill: word 01 sits in the output register, 02..05 fill the FIFO, 06 overflows
        ready_i = 1'b0;
        push_i = 1'b1;
        data_i = 5'h01; tick();
        data_i = 5'h02; tick();
        data_i = 5'h03; tick();
        data_i = 5'h04; tick();
        check("t2_notfull", 32'(full_o), 32'd0);
        data_i = 5'h05; tick();
        check("t2_full", 32'(full_o), 32'd1);
        check("t2_noovf", 32'(overflow_o), 32'd0);
        data_i = 5'h06; tick();
        check("t2_ovf", 32'(overflow_o), 32'd1);
        check("t2_full2", 32'(full_o), 32'd1);
        push_i = 1'b0;
        tick();
        check("t2_ovf_clr", 32'(overflow_o), 32'd0);
        check("t2_state", 32'(state_o), 32'd2);
        check("t2_data01", 32'(data_o), 32'h01);
        ready_i = 1'b1;
        expect_word(5'h01);
        expect_word(5'h02);
        expect_word(5'h03);
        expect_word(5'h04);
        expect_word(5'h05);
        tick(); tick(); tick();
        check("t2_idle_valid", 32'(valid_o), 32'd0);
        check("t2_idle_state", 32'(state_o), 32'd0);
        check("t2_sent", 32'(sent_cnt_o), 32'd6);

        // Receiver stall: 40 cycles in VALID with ready low
        ready_i = 1'b0;
        push_i = 1'b1; data_i = 5'h11;
        tick();
        push_i = 1'b0;
        wait_valid(6);
        to_cnt = 0; first_to = 0; data_bad = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (timeout_o) begin
                to_cnt++;
                if (first_to == 0) first_to = k;
            end
            if (data_o !== 5'h11 || valid_o !== 1'b1) data_bad = 1'b1;
        end
        check("t3_to_cnt", 32'(to_cnt), 32'd2);
        check("t3_first_to", 32'(first_to), 32'd16);
        check("t3_hold", 32'(data_bad), 32'd0);
        check("t3_state", 32'(state_o), 32'd2);
        ready_i = 1'b1;
        tick();
        check("t3_done", 32'(state_o), 32'd3);
        check("t3_sent", 32'(sent_cnt_o), 32'd7);
        tick(); tick();

        // Reset while VALID with two words queued
        ready_i = 1'b0;
        push_i = 1'b1;
        data_i = 5'h15; tick();
        data_i = 5'h16; tick();
        data_i = 5'h17; tick();
        push_i = 1'b0;
        check("t4_state", 32'(state_o), 32'd2);
        check("t4_data", 32'(data_o), 32'h15);
        #2 rst = 1'b1;
        #1;
        check("t4_rst_valid", 32'(valid_o), 32'd0);
        check("t4_rst_data", 32'(data_o), 32'd0);
        check("t4_rst_state", 32'(state_o), 32'd0);
        check("t4_rst_sent", 32'(sent_cnt_o), 32'd0);
        #2 rst = 1'b0;
        ready_i = 1'b1;
        tick(); tick(); tick(); tick();
        check("t4_post_valid", 32'(valid_o), 32'd0);
        check("t4_post_state", 32'(state_o), 32'd0);
        push_i = 1'b1; data_i = 5'h0F;
        tick();
        push_i = 1'b0;
        wait_valid(6);
        check("t4_new_data", 32'(data_o), 32'h0F);
        tick();
        check("t4_new_sent", 32'(sent_cnt_o), 32'd1);

        // Counter wrap: 255 more transfers bring 1 back to 0
        data_bad = 1'b0;
        for (int i = 0; i < 255; i++) begin
            push_i = 1'b1; data_i = 5'(i);
            tick();
            push_i = 1'b0;
            wait_valid(6);
            if (data_o !== 5'(i)) data_bad = 1'b1;
            tick();
            if (i == 253) check("t5_sent255", 32'(sent_cnt_o), 32'd255);
        end
        check("t5_wrap", 32'(sent_cnt_o), 32'd0);
        check("t5_data", 32'(data_bad), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
